// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// line-level constants for the start and stop bits.
package sipo_frame_rx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic StartBit = 1'b1;
  localparam logic StopBit  = 1'b0;

endpackage

// File: rtl/sipo_word_buf.sv
// One-entry valid/ready word buffer with overrun detection.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : a complete good word is offered this cycle
//   ready_i       : consumer accepts the held word when valid_o is high
//   data_o        : held word (keeps its value after being consumed)
//   valid_o       : buffer full
//   overrun_o     : 1-cycle pulse when a pushed word is dropped (full, not ready)
module sipo_word_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [Width-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             overrun_d, overrun_q;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (push_i) begin
      // A full buffer drained on this same edge can take the new word.
      if (!valid_q || ready_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-in parallel-out frame receiver. Frame, one bit per clock:
// start(1), D0..D[DataW-1] LSB first, optional parity, stop(0).
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   din_i          : serial line, idle low
//   dout_o         : received word, stable while dout_valid_o is high
//   dout_valid_o   : word buffer full
//   dout_ready_i   : consumer accepts word on valid & ready
//   parity_err_o   : 1-cycle pulse, parity mismatch, frame dropped
//   frame_err_o    : 1-cycle pulse, stop bit was 1, frame dropped
//   overrun_o      : 1-cycle pulse, good frame dropped because buffer full
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int unsigned DataW     = 8,
  parameter int unsigned ParityEn  = 1,
  parameter int unsigned ParityOdd = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  output logic [DataW-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(DataW + 1);

  state_e           state_q;
  logic [DataW-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             par_mis_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             par_mis;
  logic             push;

  // Mismatch when the XOR over data and parity bit differs from the target.
  assign par_mis = (^sr_q) ^ din_i ^ 1'(ParityOdd);

  // Good word is handed to the buffer on the stop-bit sampling edge itself.
  assign push = (state_q == StStop) && (din_i == StopBit) && !par_mis_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      cnt_q        <= '0;
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (din_i == StartBit) begin
            state_q   <= StData;
            cnt_q     <= '0;
            par_mis_q <= 1'b0;
          end
        end
        StData: begin
          sr_q  <= {din_i, sr_q[DataW-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DataW - 1)) begin
            state_q <= (ParityEn != 0) ? StParity : StStop;
          end
        end
        StParity: begin
          par_mis_q <= par_mis;
          state_q   <= StStop;
        end
        StStop: begin
          // A high stop bit is an error, never a fresh start bit.
          state_q <= StIdle;
          if (din_i != StopBit) begin
            frame_err_q <= 1'b1;
          end else if (par_mis_q) begin
            parity_err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sipo_word_buf #(
    .Width(DataW)
  ) u_word_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .data_i    (sr_q),
    .ready_i   (dout_ready_i),
    .data_o    (dout_o),
    .valid_o   (dout_valid_o),
    .overrun_o (overrun_o)
  );

  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx with a scoreboard of expected frame outcomes
// and a small model of the output buffer, checked at every falling edge.
module tb_sipo_frame_rx;

  localparam int unsigned DataW     = 8;
  localparam logic        ParityOdd = 1'b0;

  localparam int KGood = 0;
  localparam int KPerr = 1;
  localparam int KFerr = 2;

  typedef struct {
    logic [DataW-1:0] word;
    int               kind;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             din;
  logic [DataW-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  exp_t             exp_q[$];
  logic             done_pending;
  logic [DataW-1:0] m_dout;
  logic             m_valid;
  logic             m_perr;
  logic             m_ferr;
  logic             m_ovr;
  int               checks;
  int               errors;

  sipo_frame_rx u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .din_i        (din),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // Advance the model over the rising edge just passed, compare, then drive din.
  task automatic tick(input logic b);
    exp_t e;
    logic rdy;
    logic load;
    @(negedge clk);
    rdy    = dout_ready;
    load   = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (done_pending) begin
      done_pending = 1'b0;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.kind == KFerr) m_ferr = 1'b1;
        else if (e.kind == KPerr) m_perr = 1'b1;
        else if (!m_valid || rdy) begin
          load   = 1'b1;
          m_dout = e.word;
        end else m_ovr = 1'b1;
      end
    end
    if (load) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
    chk_outputs();
    din = b;
  endtask

  task automatic send_frame(input logic [DataW-1:0] word, input logic bad_par,
                            input logic stop, input logic rdy_stop);
    exp_t e;
    tick(1'b1);
    for (int i = 0; i < int'(DataW); i++) tick(word[i]);
    tick((^word) ^ ParityOdd ^ bad_par);
    e.word = word;
    e.kind = stop ? KFerr : (bad_par ? KPerr : KGood);
    exp_q.push_back(e);
    tick(stop);
    dout_ready   = rdy_stop;
    done_pending = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_pending = 1'b0;
    m_dout       = '0;
    m_valid      = 1'b0;
    m_perr       = 1'b0;
    m_ferr       = 1'b0;
    m_ovr        = 1'b0;
    rst_n        = 1'b0;
    din          = 1'b0;
    dout_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs();
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Fill the buffer, then abandon a frame with reset: everything returns to 0.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    m_valid = 1'b0;
    m_dout  = '0;
    chk_outputs();
    @(negedge clk);
    chk_outputs();
    rst_n = 1'b1;
    exp_q.delete();
    done_pending = 1'b0;
    dout_ready   = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Clean frame after reset, ready held high: valid for exactly one cycle.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b0);

    // Parity error: pulse, no word.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b0);

    // Framing error, then a normal frame.
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    tick(1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b0);

    // Ready low, back-to-back frames: second overruns, first held.
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    dout_ready = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Ready rises on the edge the second word completes: replaced, no overrun.
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    tick(1'b0);
    dout_ready = 1'b0;
    tick(1'b0);
    tick(1'b0);
    dout_ready = 1'b1;
    tick(1'b0);
    tick(1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
